// File: rtl/byte_decode_seq.sv
// byte_decode_seq: streaming ByteDecode_d for ML-KEM.
// Unpacks 32*d input bytes LSB-first into 256 d-bit coefficients through a
// 20-bit bit accumulator. For d = 12 each coefficient is reduced mod Q.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, d_i         job start (sampled in IDLE) and bits per coefficient
//   busy_o, done_o       job in progress / one-cycle completion pulse
//   err_o                one-cycle pulse on start with illegal d_i (0 or >12)
//   byte_valid_i/byte_i/byte_ready_o   byte input handshake
//   coef_valid_o/coef_o/coef_idx_o/coef_ready_i   coefficient output handshake
module byte_decode_seq #(
  parameter int unsigned Q      = 3329,
  parameter int unsigned N_COEF = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  d_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        coef_valid_o,
  output logic [11:0] coef_o,
  output logic [7:0]  coef_idx_o,
  input  logic        coef_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [11:0] QV       = 12'(Q);
  localparam logic [7:0]  LAST_IDX = 8'(N_COEF - 1);

  state_t      state_q, state_d;
  logic [3:0]  d_q;
  logic [19:0] acc_q;
  logic [4:0]  bcnt_q;
  logic [8:0]  bytes_in_q;
  logic [7:0]  emit_cnt_q;
  logic [11:0] coef_q;
  logic [7:0]  idx_q;
  logic        cvalid_q;
  logic        err_q;

  logic        d_ok, start_ok, run;
  logic [4:0]  d5;
  logic [8:0]  byte_lim;
  logic        byte_acc, emit, hs;
  logic [19:0] byte_shift;
  logic [11:0] mask, raw, coef_red;

  assign d_ok     = (d_i != 4'd0) && (d_i <= 4'd12);
  assign start_ok = (state_q == S_IDLE) && start_i && d_ok;
  assign run      = (state_q == S_RUN);
  assign d5       = {1'b0, d_q};
  assign byte_lim = {d_q, 5'b0};

  assign byte_ready_o = run && (bcnt_q < d5) && (bytes_in_q < byte_lim);
  assign byte_acc     = byte_valid_i && byte_ready_o;
  // A stalled output blocks the next emit, which in turn keeps bcnt >= d and
  // so holds off byte intake: accept and emit can never coincide.
  assign emit         = run && (bcnt_q >= d5) && (!cvalid_q || coef_ready_i);
  assign hs           = cvalid_q && coef_ready_i;

  // bcnt < d <= 12 on accept, so the byte lands within acc[19:0].
  assign byte_shift = {12'b0, byte_i} << bcnt_q;
  assign mask       = 12'((13'd1 << d_q) - 13'd1);
  assign raw        = acc_q[11:0] & mask;
  assign coef_red   = ((d_q == 4'd12) && (raw >= QV)) ? raw - QV : raw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_RUN;
      S_RUN: begin
        busy_o = 1'b1;
        if (hs && (idx_q == LAST_IDX)) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q        <= '0;
      acc_q      <= '0;
      bcnt_q     <= '0;
      bytes_in_q <= '0;
      emit_cnt_q <= '0;
      coef_q     <= '0;
      idx_q      <= '0;
      cvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start_i && !d_ok;
      if (start_ok) begin
        d_q        <= d_i;
        acc_q      <= '0;
        bcnt_q     <= '0;
        bytes_in_q <= '0;
        emit_cnt_q <= '0;
      end else if (run) begin
        if (byte_acc) begin
          acc_q      <= acc_q | byte_shift;
          bcnt_q     <= bcnt_q + 5'd8;
          bytes_in_q <= bytes_in_q + 9'd1;
        end
        if (emit) begin
          coef_q     <= coef_red;
          idx_q      <= emit_cnt_q;
          emit_cnt_q <= emit_cnt_q + 8'd1;
          acc_q      <= acc_q >> d_q;
          bcnt_q     <= bcnt_q - d5;
          cvalid_q   <= 1'b1;
        end else if (hs) begin
          cvalid_q   <= 1'b0;
        end
      end
    end
  end

  assign err_o        = err_q;
  assign coef_valid_o = cvalid_q;
  assign coef_o       = coef_q;
  assign coef_idx_o   = idx_q;

endmodule

// File: tb/tb_byte_decode_seq.sv
// Self-checking bench for byte_decode_seq: byte stimulus queue in, expected
// coefficient scoreboard queue popped on every output handshake.
module tb_byte_decode_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  d_i = '0;
  logic        busy_o, done_o, err_o;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o;
  logic        coef_valid_o;
  logic [11:0] coef_o;
  logic [7:0]  coef_idx_o;
  logic        coef_ready_i = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0]  byte_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  byte_arr[384];

  always #5 clk_i = ~clk_i;

  byte_decode_seq #(.Q(3329), .N_COEF(256)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .coef_valid_o(coef_valid_o), .coef_o(coef_o), .coef_idx_o(coef_idx_o),
    .coef_ready_i(coef_ready_i)
  );

  // Bit-serial reference: coefficient k is stream bits d*k .. d*k+d-1.
  function automatic logic [11:0] ref_coef(input int d, input int k);
    int x = 0;
    for (int b = 0; b < d; b++) begin
      int pos = d * k + b;
      logic [7:0] by = byte_arr[pos / 8];
      x = x | (int'(by[pos % 8]) << b);
    end
    if (d == 12 && x >= 3329) x = x - 3329;
    return 12'(x);
  endfunction

  task automatic load_random(input int d);
    byte_q.delete(); exp_q.delete();
    for (int i = 0; i < 32 * d; i++) begin
      byte_arr[i] = 8'($urandom_range(0, 255));
      byte_q.push_back(byte_arr[i]);
    end
    for (int k = 0; k < 256; k++) exp_q.push_back(ref_coef(d, k));
  endtask

  task automatic run_job(input int d, input bit rand_ready, input bit inject,
                         input int abort_at);
    int n_coef = 0, n_bytes = 0, n_done = 0, cyc = 0, post = 0;
    bit held = 0, prev_acc = 0;
    logic [11:0] hc, ev;
    logic [7:0] hi;
    @(negedge clk_i); start_i = 1'b1; d_i = d[3:0];
    @(negedge clk_i); start_i = 1'b0; d_i = '0;
    chk_cnt++;
    if (busy_o !== 1'b1 || byte_ready_o !== 1'b1)
      $display("FAIL start_latency d=%0d: busy=%b ready=%b expected 1 1", d, busy_o, byte_ready_o);
    else pass_cnt++;
    while (cyc < 20000) begin
      cyc++;
      byte_valid_i = (byte_q.size() > 0);
      byte_i       = byte_valid_i ? byte_q[0] : 8'h00;
      coef_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i      = inject && (cyc == 50);
      d_i          = (inject && cyc == 50) ? 4'd5 : 4'd0;
      if (held) begin
        chk_cnt++;
        if (coef_valid_o !== 1'b1 || coef_o !== hc || coef_idx_o !== hi)
          $display("FAIL stall_hold: valid=%b coef=%0d idx=%0d expected 1 %0d %0d",
                   coef_valid_o, coef_o, coef_idx_o, hc, hi);
        else pass_cnt++;
      end
      if (d == 8 && prev_acc) begin
        chk_cnt++;
        if (byte_ready_o !== 1'b0)
          $display("FAIL ready_while_full: byte_ready=%b expected 0", byte_ready_o);
        else pass_cnt++;
      end
      prev_acc = byte_valid_i && byte_ready_o;
      if (prev_acc) begin
        void'(byte_q.pop_front());
        n_bytes++;
      end
      held = coef_valid_o && !coef_ready_i;
      hc = coef_o; hi = coef_idx_o;
      if (coef_valid_o && coef_ready_i) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_coef: got idx %0d expected no output", coef_idx_o);
        end else begin
          ev = exp_q.pop_front();
          if (coef_o !== ev || coef_idx_o !== n_coef[7:0])
            $display("FAIL coef d=%0d: got %0d idx %0d expected %0d idx %0d",
                     d, coef_o, coef_idx_o, ev, n_coef);
          else pass_cnt++;
        end
        n_coef++;
      end
      if (done_o) n_done++;
      @(negedge clk_i);
      if (abort_at > 0 && n_coef > abort_at) break;
      if (n_done > 0) begin
        post++;
        if (post > 4) break;
      end
    end
    byte_valid_i = 1'b0; start_i = 1'b0;
    if (abort_at > 0) begin
      chk_cnt++;
      if (n_coef <= abort_at) $display("FAIL abort_timeout: got %0d coefs expected > %0d", n_coef, abort_at);
      else pass_cnt++;
      return;
    end
    chk_cnt++;
    if (n_done !== 1 || n_bytes !== 32 * d || exp_q.size() !== 0 || n_coef !== 256)
      $display("FAIL job_end d=%0d: done=%0d bytes=%0d coefs=%0d left=%0d expected 1 %0d 256 0",
               d, n_done, n_bytes, n_coef, exp_q.size(), 32 * d);
    else pass_cnt++;
    chk_cnt++;
    if (busy_o !== 1'b0 || coef_valid_o !== 1'b0)
      $display("FAIL idle_after_job: busy=%b valid=%b expected 0 0", busy_o, coef_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    #1;
    chk_cnt++;
    if ({busy_o, done_o, err_o, byte_ready_o, coef_valid_o} !== 5'b0 ||
        coef_o !== 12'd0 || coef_idx_o !== 8'd0)
      $display("FAIL reset_values: flags=%b coef=%0d idx=%0d expected 0 0 0",
               {busy_o, done_o, err_o, byte_ready_o, coef_valid_o}, coef_o, coef_idx_o);
    else pass_cnt++;
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_d1;
    logic [11:0] pat[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    byte_q.delete(); exp_q.delete();
    byte_q.push_back(8'hA5);
    for (int i = 1; i < 32; i++) byte_q.push_back(8'h00);
    for (int k = 0; k < 8; k++) exp_q.push_back(pat[k]);
    for (int k = 8; k < 256; k++) exp_q.push_back(12'd0);
    run_job(1, 1'b0, 1'b0, 0);
    // Surplus bytes after completion must not be taken.
    byte_valid_i = 1'b1; byte_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (byte_ready_o !== 1'b0) $display("FAIL post_job_ready: got %b expected 0", byte_ready_o);
      else pass_cnt++;
      @(negedge clk_i);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_d12;
    logic [7:0] hdr[6] = '{8'h00, 8'h0D, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    byte_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) byte_q.push_back(hdr[i]);
    for (int i = 6; i < 384; i++) byte_q.push_back(8'h00);
    exp_q.push_back(12'd3328); exp_q.push_back(12'd0);
    exp_q.push_back(12'd766);  exp_q.push_back(12'd766);
    for (int k = 4; k < 256; k++) exp_q.push_back(12'd0);
    run_job(12, 1'b0, 1'b0, 0);
  endtask

  task automatic test_d8_stall;
    byte_q.delete(); exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      byte_q.push_back(8'(i));
      exp_q.push_back(12'(i));
    end
    run_job(8, 1'b1, 1'b0, 0);
  endtask

  task automatic test_illegal_d;
    logic [3:0] bad[2] = '{4'd0, 4'd13};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk_i); start_i = 1'b1; d_i = bad[t];
      @(negedge clk_i); start_i = 1'b0; d_i = '0;
      chk_cnt++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || byte_ready_o !== 1'b0)
        $display("FAIL illegal_d=%0d: err=%b busy=%b ready=%b expected 1 0 0",
                 bad[t], err_o, busy_o, byte_ready_o);
      else pass_cnt++;
      @(negedge clk_i);
      chk_cnt++;
      if (err_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL err_pulse_width: err=%b busy=%b expected 0 0", err_o, busy_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midjob;
    load_random(10);
    run_job(10, 1'b0, 1'b0, 100);
    rst_ni = 1'b0;
    #1;
    chk_cnt++;
    if ({busy_o, done_o, err_o, byte_ready_o, coef_valid_o} !== 5'b0 ||
        coef_o !== 12'd0 || coef_idx_o !== 8'd0)
      $display("FAIL midjob_reset: flags=%b coef=%0d idx=%0d expected 0 0 0",
               {busy_o, done_o, err_o, byte_ready_o, coef_valid_o}, coef_o, coef_idx_o);
    else pass_cnt++;
    @(negedge clk_i); @(negedge clk_i);
    chk_cnt++;
    if (done_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL aborted_done: done=%b busy=%b expected 0 0", done_o, busy_o);
    else pass_cnt++;
    rst_ni = 1'b1;
    byte_q.delete(); exp_q.delete();
    for (int i = 0; i < 128; i++) byte_q.push_back(8'h21);
    for (int k = 0; k < 256; k++) exp_q.push_back((k % 2 == 0) ? 12'd1 : 12'd2);
    run_job(4, 1'b0, 1'b0, 0);
  endtask

  task automatic test_start_ignored;
    load_random(11);
    run_job(11, 1'b1, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_d1();
    test_d12();
    test_d8_stall();
    test_illegal_d();
    test_reset_midjob();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
